// File: rtl/npu_dot_seq.sv
`default_nettype none
// ============================================================================
// npu_dot_seq : job sequencer and wide accumulator for the 8-lane int8 add tree
// Revision    : 1.0
// ============================================================================
module npu_dot_seq #(
   parameter int LEN_W    = 8,
   parameter int ACC_W    = 32,
   parameter int TREE_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_signed,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   input  logic [63:0]      in_para,
   output logic [63:0]      tree_data,
   output logic [63:0]      tree_para,
   output logic             tree_signed,
   input  logic [18:0]      tree_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_result
);

   localparam int PIPE_D = TREE_LAT + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   state_t                  r_state;
   logic [LEN_W-1:0]        r_len;
   logic [LEN_W-1:0]        r_issued;
   logic [LEN_W-1:0]        r_received;
   logic [ACC_W-1:0]        r_acc;
   logic [PIPE_D-1:0]       r_tag;

   logic                    w_accept;
   logic                    w_tag_out;
   logic [PIPE_D-1:0]       w_tag_next;
   logic signed [ACC_W-1:0] w_tree_ext;
   logic [ACC_W-1:0]        w_acc_sum;
   logic [LEN_W-1:0]        w_issue_inc;
   logic [LEN_W-1:0]        w_recv_inc;
   logic                    w_accumulate;

   assign w_accept     = in_valid & in_ready;
   assign w_tag_out    = r_tag[PIPE_D-1];
   assign w_tree_ext   = ACC_W'($signed(tree_result));
   assign w_acc_sum    = r_acc + w_tree_ext;
   assign w_issue_inc  = r_issued + LEN_W'(1);
   assign w_recv_inc   = r_received + LEN_W'(1);
   assign w_accumulate = w_tag_out & ((r_state == ST_RUN) | (r_state == ST_DRAIN));

   // Tag shift register tracks which tree results belong to real beats.
   generate
      if (PIPE_D > 1) begin : g_tag_multi
         assign w_tag_next = {r_tag[PIPE_D-2:0], w_accept};
      end else begin : g_tag_single
         assign w_tag_next = w_accept;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_len       <= '0;
         r_issued    <= '0;
         r_received  <= '0;
         r_acc       <= '0;
         r_tag       <= '0;
         busy        <= 1'b0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         tree_data   <= '0;
         tree_para   <= '0;
         tree_signed <= 1'b0;
      end else begin
         r_tag <= w_tag_next;

         if (w_accept) begin
            tree_data <= in_data;
            tree_para <= in_para;
            r_issued  <= w_issue_inc;
         end else begin
            tree_data <= '0;
            tree_para <= '0;
         end

         if (w_accumulate) begin
            r_acc      <= w_acc_sum;
            r_received <= w_recv_inc;
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_len       <= cfg_len;
                  tree_signed <= cfg_signed;
                  r_acc       <= '0;
                  r_issued    <= '0;
                  r_received  <= '0;
                  busy        <= 1'b1;
                  if (cfg_len != '0) begin
                     r_state  <= ST_RUN;
                     in_ready <= 1'b1;
                  end else begin
                     r_state    <= ST_OUT;
                     out_valid  <= 1'b1;
                     out_result <= '0;
                  end
               end
            end

            ST_RUN: begin
               if (w_accept && (w_issue_inc == r_len)) begin
                  r_state  <= ST_DRAIN;
                  in_ready <= 1'b0;
               end
            end

            ST_DRAIN: begin
               // The final accumulate lands on the same edge as the move to OUT.
               if (w_accumulate && (w_recv_inc == r_len)) begin
                  r_state    <= ST_OUT;
                  out_valid  <= 1'b1;
                  out_result <= w_acc_sum;
               end
            end

            ST_OUT: begin
               if (out_ready) begin
                  r_state   <= ST_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/npu_dot_seq.md
Name: npu_dot_seq

Overview:
Sequencer and accumulator for the 8-lane int8 add tree (NPU_ADD_TREE_TOP).
- Accepts a configured number of 64-bit data/para beat pairs over a valid/ready stream.
- Issues one beat per cycle to the tree and sign-extends and accumulates the 19-bit tree results into a wide accumulator.
- Presents one dot-product result per job on a valid/ready output.
- Sits between the NPU operand buffers and the cube add tree, and owns the tree's inputs and signed mode for the duration of a job.

Parameters:
- LEN_W, 8, width of cfg_len (beats per job, 0 .. 2^LEN_W-1).
- ACC_W, 32, accumulator/result width (must be at least 19).
- TREE_LAT, 1, register stages in the add tree from its inputs to add_result.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job start pulse; sampled only in IDLE.
- cfg_len  in  LEN_W  beats in job; latched on accepted start.
- cfg_signed  in  1  data lanes signed (1) / unsigned (0); latched on accepted start.
- busy  out  1  high in any state except IDLE.
- in_valid  in  1  beat available.
- in_ready  out  1  sequencer accepts beat.
- in_data  in  64  8 data bytes.
- in_para  in  64  8 parameter bytes (always signed).
- tree_data  out  64  to add tree add_tree_data.
- tree_para  out  64  to add tree add_tree_para.
- tree_signed  out  1  to add tree is_signed_data.
- tree_result  in  19  from add tree add_result, signed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  ACC_W  signed dot-product sum.

Behaviour:
- States are IDLE, RUN, DRAIN, OUT.
- Reset values: state IDLE, busy 0, in_ready 0, out_valid 0, out_result 0, tree_data 0, tree_para 0, tree_signed 0, accumulator 0, counters 0, tag pipe 0.
- rst during any state aborts the job: in-flight tree results are discarded and no out_valid is produced.
- IDLE: when start=1, latch cfg_len and cfg_signed, clear the accumulator and both counters.
  - cfg_len != 0: go to RUN.
  - cfg_len == 0: go to OUT with out_result 0.
- start outside IDLE is ignored. tree_signed holds the latched mode from the start edge until the next start.
- RUN: in_ready = 1 while issued < len.
  - Accept a beat on in_valid & in_ready.
  - On the same edge, register in_data/in_para into tree_data/tree_para and push tag 1 into a (TREE_LAT+1)-deep valid pipe.
  - Cycles without an accepted beat load zeros into tree_data/tree_para and push tag 0.
  - When the last beat is accepted (issued reaches len), go to DRAIN; in_ready drops on the next cycle.
- Tag pipe: a tag pushed at edge e emerges at edge e+TREE_LAT+1, aligned with tree_result for that beat.
  - On an emerging tag 1: acc <= acc + sign_extend(tree_result) mod 2^ACC_W, and received increments.
  - tree_result is always treated as signed (para is signed in both modes); wrap-around on overflow is silent.
  - Accumulation occurs in RUN and DRAIN alike.
- DRAIN: in_ready = 0. When received reaches len (counting the accumulate on the same edge), go to OUT.
- OUT: out_valid = 1 and out_result = acc. Both hold stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE with out_valid 0 on the next cycle.
  - A start in the same cycle as the handshake is ignored, because the sequencer is not yet in IDLE.
- Latency, continuous in_valid, start at cycle 0:
  - in_ready is high in cycles 1..len.
  - out_valid first rises at cycle len+TREE_LAT+2. With TREE_LAT=1 and len=1, that is cycle 4.
- Throughput: one beat per cycle; gaps in in_valid only lengthen the job.
- Max len gives |sum| ≤ 255·128·8·255 < 2^27, so ACC_W=32 never wraps at LEN_W=8.

Test Plan:
- Unsigned ones, cfg_signed=0, len=1: in_data=0x0101010101010101, in_para=0x0202020202020202 → out_result=16, out_valid at cycle 4 (TREE_LAT=1).
- Mode check, len=1, in_data=0xFFFFFFFFFFFFFFFF, in_para=0x0101010101010101: cfg_signed=1 → −8 (0xFFFFFFF8); cfg_signed=0 → 2040.
- len=3 with in_valid toggling 1,0,1,0,1: 3 beats with para lanes 0x01, data lanes 3, 5, −2 signed → 8·(3+5−2)=48. A 4th offered beat must see in_ready=0.
- len=0 start → OUT within 1 cycle, out_result=0, in_ready never asserts.
- Backpressure: hold out_ready=0 for 10 cycles in OUT → out_valid and out_result stable, busy=1, start pulses ignored. Release → out_valid drops the next cycle.
- Reset mid-RUN, after 2 of 5 beats → all outputs at reset values the next cycle. A fresh len=1 job then returns the correct value, unpolluted by stale tree results.
- Randomized jobs, 10000 iterations, compared against a behavioural per-lane model in both modes → zero mismatches.
